serial_operand_serializer: RTL and testbench
============================================

// Module: serial_operand_serializer
//
// PURPOSE
//  Upstream feeder for the bit-serial adder stage. Accepts operand pairs as
//  parallel words over a valid/ready handshake and emits them LSB-first, one
//  bit pair per cycle, as a/b with vld and last qualifiers. A one-entry
//  holding buffer keeps back-to-back operands gap-free. A hold input inserts
//  vld=0 bubbles mid-word.
//
// PARAMETERS
//  WIDTH  8  operand width in bits; legal range >= 1
//
// PORTS
//  clk     in   1      clock, rising edge
//  rst     in   1      asynchronous reset, ACTIVE-LOW (rst==0 resets)
//  in_vld  in   1      parallel operand pair valid
//  in_rdy  out  1      block can accept a pair this cycle
//  in_a    in   WIDTH  operand A, parallel
//  in_b    in   WIDTH  operand B, parallel
//  hold    in   1      1 = emit no bit this cycle (bubble)
//  vld     out  1      a/b/last valid this cycle
//  a       out  1      operand A bit, LSB first
//  b       out  1      operand B bit, LSB first
//  last    out  1      MSB of current word (only with vld=1)
//
// BEHAVIOUR
//  Reset (rst==0, async): vld=a=b=last=0; shifter idle; buffer empty;
//   bit counter 0; in_rdy=1 once rst releases.
//  Storage: shifter (sh_a, sh_b, cnt 0..WIDTH-1, active flag).
//   Holding buffer (buf_a, buf_b, buf_full).
//  in_rdy = !buf_full (combinational, no in_vld dependency).
//   A handshake occurs when in_vld && in_rdy at a rising edge.
//  Emit condition per cycle: emit = active && !hold.
//  Outputs are registered. At each edge:
//   vld<=emit; a<=emit?sh_a[0]:0; b<=emit?sh_b[0]:0;
//   last<=emit&&(cnt==WIDTH-1).
//   With vld=0, a, b and last are always 0.
//  On emit: sh_a/sh_b shift right by 1 and cnt increments.
//   On the MSB bit (cnt==WIDTH-1), cnt returns to 0 and the word ends.
//  Shifter load: the shifter is free when !active, or when emitting its MSB
//   this cycle. When free:
//   - if buf_full: load from buffer, buffer empties;
//   - else if handshake: load directly from in_a/in_b (bypass);
//   - else active<=0.
//  Handshake while the shifter is not free, or while the buffer feeds the
//   shifter: the pair goes to the buffer and buf_full<=1.
//  Latency: handshake at edge N into an idle shifter (hold=0) gives bit0
//   with vld=1 in the cycle after edge N+1. The word occupies WIDTH vld
//   cycles plus one per hold cycle.
//  Throughput: buffered words stream with no vld gap. The next bit0
//   follows the previous last directly.
//  hold: freezes shifter, cnt and active. It does not block handshakes.
//   The buffer still fills when empty.
//  WIDTH==1: every emitted bit has last=1.
//  Reset mid-word: the word is discarded. No partial output resumes.
//  Backpressure: the downstream stage is always ready. Bubbles come only
//   from hold or an empty pipeline.
//
// TESTING
//  1. WIDTH=8, one pair a=0x5A b=0x0F, hold=0 -> 8 vld cycles;
//     a=0,1,0,1,1,0,1,0; b=1,1,1,1,0,0,0,0; last only on 8th; then vld=0.
//  2. Three pairs presented back-to-back -> 24 consecutive vld cycles.
//     last at bits 8/16/24. in_rdy drops to 0 while buffer full.
//  3. Hold=1 for 3 cycles after bit 2 of 0xFF/0x01 -> 3 vld=0 cycles.
//     Remaining bits resume intact. Total 11 cycles, last on final vld.
//  4. Assert rst=0 asynchronously mid-word (bit 4) -> vld/a/b/last=0
//     immediately, in_rdy=1 after release, next word starts at bit0.
//  5. WIDTH=1, pairs {1,1},{0,1} back-to-back -> 2 vld cycles, last=1 on both.
//  6. Scoreboard: random pairs and hold feed the serial adder.
//     The deserialized sums equal (in_a+in_b) mod 2^WIDTH.

Source files
------------

// File: rtl/serial_operand_serializer_if.sv
// Bundle for the parallel operand handshake, the hold control and the bit-serial output.
// The serializer takes the slave side; the feeder and the bench take the master side.
interface serial_operand_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_vld;
    logic             in_rdy;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             hold;
    logic             vld;
    logic             a;
    logic             b;
    logic             last;

    modport master (
        output in_vld, in_a, in_b, hold,
        input  in_rdy, vld, a, b, last
    );

    modport slave (
        input  in_vld, in_a, in_b, hold,
        output in_rdy, vld, a, b, last
    );
endinterface

// File: rtl/serial_operand_serializer.sv
// Turns parallel operand pairs into an LSB-first bit-pair stream for the bit-serial adder.
// A one-entry holding buffer sits in front of the shifter so back-to-back words stream gap-free.
module serial_operand_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    serial_operand_serializer_if.slave   bus
);
    localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] buf_a;
    logic [WIDTH-1:0] buf_b;
    logic [CW-1:0]    cnt;
    logic             active;
    logic             buf_full;

    logic             emit;
    logic             at_msb;
    logic             sh_free;
    logic             hs;

    logic             vld_p1;
    logic             a_p1;
    logic             b_p1;
    logic             last_p1;

    assign emit    = active && !bus.hold;
    assign at_msb  = (cnt == CNT_MAX);
    // The shifter may take a new word while its MSB is leaving this very cycle.
    assign sh_free = !active || (emit && at_msb);
    assign hs      = bus.in_vld && !buf_full;

    assign bus.in_rdy = !buf_full;
    assign bus.vld    = vld_p1;
    assign bus.a      = a_p1;
    assign bus.b      = b_p1;
    assign bus.last   = last_p1;

    // Stage p1: registered serial outputs plus shifter/buffer control state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1   <= 1'b0;
            a_p1     <= 1'b0;
            b_p1     <= 1'b0;
            last_p1  <= 1'b0;
            active   <= 1'b0;
            buf_full <= 1'b0;
            cnt      <= '0;
        end else begin
            vld_p1  <= emit;
            a_p1    <= emit & sh_a[0];
            b_p1    <= emit & sh_b[0];
            last_p1 <= emit & at_msb;

            if (sh_free) begin
                cnt <= '0;
                if (buf_full) begin
                    active   <= 1'b1;
                    buf_full <= 1'b0;
                end else if (hs) begin
                    active <= 1'b1;
                end else begin
                    active <= 1'b0;
                end
            end else begin
                if (emit) begin
                    cnt <= cnt + CW'(1);
                end
                if (hs) begin
                    buf_full <= 1'b1;
                end
            end
        end
    end

    // Operand storage carries no reset; the control flags above decide what is meaningful.
    always_ff @(posedge clk) begin
        if (sh_free && buf_full) begin
            sh_a <= buf_a;
            sh_b <= buf_b;
        end else if (sh_free && hs) begin
            sh_a <= bus.in_a;
            sh_b <= bus.in_b;
        end else if (emit) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
        end

        if (hs && !sh_free) begin
            buf_a <= bus.in_a;
            buf_b <= bus.in_b;
        end
    end
endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: scoreboarded bit streams for WIDTH=8 and WIDTH=1 instances,
// with a bit-serial adder model reassembling the WIDTH=8 sums.
module tb_serial_operand_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_operand_serializer_if #(.WIDTH(8)) bus8 ();
    serial_operand_serializer_if #(.WIDTH(1)) bus1 ();

    serial_operand_serializer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_operand_serializer #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic a;
        logic b;
        logic last;
    } bit_t;

    int         checks = 0;
    int         errors = 0;
    bit_t       q8[$];
    bit_t       q1[$];
    logic [7:0] sum_q[$];
    bit_t       e8, e1;
    logic [7:0] acc;
    int         acc_i;
    logic       carry;
    logic       s;
    bit         rnd_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the WIDTH=8 instance, including the serial adder model.
    always @(negedge clk) begin
        if (!rst) begin
            acc_i = 0;
            carry = 1'b0;
            acc   = '0;
        end else if (bus8.vld) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL w8_extra_bit: got vld=1 expected no pending bit");
            end else begin
                e8 = q8.pop_front();
                check("w8_bit", 32'({bus8.a, bus8.b, bus8.last}), 32'(e8));
            end
            s     = bus8.a ^ bus8.b ^ carry;
            carry = (bus8.a & bus8.b) | (carry & (bus8.a ^ bus8.b));
            if (acc_i < 8) acc[acc_i] = s;
            acc_i++;
            if (bus8.last) begin
                if (sum_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w8_sum: got sum %0h expected no pending word", acc);
                end else begin
                    check("w8_sum", 32'(acc), 32'(sum_q.pop_front()));
                end
                acc_i = 0;
                carry = 1'b0;
                acc   = '0;
            end
        end else begin
            check("w8_idle_zero", 32'({bus8.a, bus8.b, bus8.last}), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (bus1.vld) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL w1_extra_bit: got vld=1 expected no pending bit");
                end else begin
                    e1 = q1.pop_front();
                    check("w1_bit", 32'({bus1.a, bus1.b, bus1.last}), 32'(e1));
                end
            end else begin
                check("w1_idle_zero", 32'({bus1.a, bus1.b, bus1.last}), 32'd0);
            end
        end
    end

    task automatic send8(input logic [7:0] x, input logic [7:0] y);
        bit_t e;
        logic ok;
        int   g;
        for (int i = 0; i < 8; i++) begin
            e.a    = x[i];
            e.b    = y[i];
            e.last = (i == 7);
            q8.push_back(e);
        end
        sum_q.push_back(8'(x + y));
        @(negedge clk);
        bus8.in_vld = 1'b1;
        bus8.in_a   = x;
        bus8.in_b   = y;
        ok = bus8.in_rdy;
        g  = 0;
        while (!ok && g < 100) begin
            @(negedge clk);
            ok = bus8.in_rdy;
            g++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL w8_handshake_timeout: got in_rdy=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1 bus8.in_vld = 1'b0;
    endtask

    task automatic send1(input logic x, input logic y);
        bit_t e;
        logic ok;
        int   g;
        e.a    = x;
        e.b    = y;
        e.last = 1'b1;
        q1.push_back(e);
        @(negedge clk);
        bus1.in_vld  = 1'b1;
        bus1.in_a[0] = x;
        bus1.in_b[0] = y;
        ok = bus1.in_rdy;
        g  = 0;
        while (!ok && g < 100) begin
            @(negedge clk);
            ok = bus1.in_rdy;
            g++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL w1_handshake_timeout: got in_rdy=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1 bus1.in_vld = 1'b0;
    endtask

    // Measures the stream span from first vld to the requested number of last flags,
    // optionally inserting a hold bubble run once hold_at bits have been seen.
    task automatic measure(input int exp_lasts, input int exp_span, input int exp_vld,
                           input int hold_at, input int hold_len, input string name);
        int span = 0, nv = 0, nl = 0, g = 0, hc = 0;
        bit hold_done = 1'b0;
        @(negedge clk);
        while (!bus8.vld && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!bus8.vld) begin
            checks++;
            errors++;
            $display("FAIL %s_start: got no vld expected a word within 100 cycles", name);
            return;
        end
        g = 0;
        while (nl < exp_lasts && g < 300) begin
            span++;
            if (bus8.vld) nv++;
            if (bus8.vld && bus8.last) nl++;
            if (bus8.hold) begin
                hc++;
                if (hc == hold_len) bus8.hold = 1'b0;
            end else if (!hold_done && hold_len > 0 && nv == hold_at) begin
                bus8.hold = 1'b1;
                hold_done = 1'b1;
            end
            if (nl < exp_lasts) begin
                @(negedge clk);
                g++;
            end
        end
        check({name, "_span"}, 32'(span), 32'(exp_span));
        check({name, "_vld"}, 32'(nv), 32'(exp_vld));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, nv, first, lastc;
        bus8.in_vld = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.hold = 1'b0;
        bus1.in_vld = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.hold = 1'b0;
        rnd_done = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_outputs", 32'({bus8.vld, bus8.a, bus8.b, bus8.last}), 32'd0);
        rst = 1'b1;
        #1 check("rst_rdy", 32'(bus8.in_rdy), 32'd1);

        // Single word: 0x5A / 0x0F
        fork
            send8(8'h5A, 8'h0F);
            measure(1, 8, 8, 0, 0, "t1");
        join
        repeat (4) @(negedge clk);

        // Three back-to-back words
        fork
            begin
                send8(8'h01, 8'hFF);
                send8(8'h80, 8'h80);
                @(negedge clk);
                check("t2_rdy_low", 32'(bus8.in_rdy), 32'd0);
                send8(8'hC3, 8'h3D);
            end
            measure(3, 24, 24, 0, 0, "t2");
        join
        repeat (4) @(negedge clk);

        // Hold bubbles mid-word
        fork
            send8(8'hFF, 8'h01);
            measure(1, 11, 8, 2, 3, "t3");
        join
        repeat (4) @(negedge clk);

        // Asynchronous reset mid-word
        send8(8'hC3, 8'h3C);
        nv = 0;
        g  = 0;
        while (nv < 4 && g < 100) begin
            @(negedge clk);
            if (bus8.vld) nv++;
            g++;
        end
        check("t4_bits_before_rst", 32'(nv), 32'd4);
        #2 rst = 1'b0;
        #1 check("t4_async_clear", 32'({bus8.vld, bus8.a, bus8.b, bus8.last}), 32'd0);
        q8.delete();
        sum_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("t4_rdy_after", 32'(bus8.in_rdy), 32'd1);
        fork
            send8(8'h96, 8'h69);
            measure(1, 8, 8, 0, 0, "t4_next");
        join
        repeat (4) @(negedge clk);

        // WIDTH=1 back-to-back pairs
        fork
            begin
                send1(1'b1, 1'b1);
                send1(1'b0, 1'b1);
            end
            begin
                nv = 0; first = -1; lastc = -1;
                for (int c = 0; c < 12; c++) begin
                    @(negedge clk);
                    if (bus1.vld) begin
                        nv++;
                        if (first < 0) first = c;
                        lastc = c;
                    end
                end
                check("t5_vld_count", 32'(nv), 32'd2);
                check("t5_span", 32'(lastc - first + 1), 32'd2);
            end
        join

        // Random pairs with random hold
        fork
            begin
                for (int k = 0; k < 16; k++) send8(8'($urandom), 8'($urandom));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    bus8.hold = ($urandom_range(0, 3) == 0);
                end
                bus8.hold = 1'b0;
            end
        join

        g = 0;
        while ((q8.size() > 0 || q1.size() > 0) && g < 400) begin
            @(negedge clk);
            g++;
        end
        check("drain_w8", 32'(q8.size()), 32'd0);
        check("drain_w1", 32'(q1.size()), 32'd0);
        check("drain_sums", 32'(sum_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
